// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register file write-port arbiter with pending-load scoreboard
//
// Purpose: shares the single register file write port between the execute (EXE)
// and load/store (LSU) writeback paths, tracks registers awaiting load data so
// decode can stall on RAW hazards, and keeps EXE off registers with loads in flight.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   exe_valid_i/exe_ready_o          EXE writeback handshake
//   exe_rd_i, exe_data_i             EXE destination register and data
//   lsu_valid_i/lsu_ready_o          LSU load-return writeback handshake
//   lsu_rd_i, lsu_data_i             LSU destination register and data
//   lsu_issue_i, lsu_issue_rd_i      load issued to memory and its destination
//   rs1_addr_i, rs2_addr_i           decode source register queries
//   rs1_pending_o, rs2_pending_o     source register awaits a load
//   pending_o                        scoreboard bitmap (bit 0 always 0)
//   rf_we_o, rf_rd_addr_o, rf_rd_data_o  registered register file write port
module rf_wb_scheduler #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exe_valid_i,
  output logic                exe_ready_o,
  input  logic [ADDR_W-1:0]   exe_rd_i,
  input  logic [DATA_W-1:0]   exe_data_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic [ADDR_W-1:0]   lsu_rd_i,
  input  logic [DATA_W-1:0]   lsu_data_i,
  input  logic                lsu_issue_i,
  input  logic [ADDR_W-1:0]   lsu_issue_rd_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  output logic                rs1_pending_o,
  output logic                rs2_pending_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                rf_we_o,
  output logic [ADDR_W-1:0]   rf_rd_addr_o,
  output logic [DATA_W-1:0]   rf_rd_data_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CNT_W-1:0]    starve_cnt;
  logic                exe_eligible;
  logic                lsu_eligible;
  logic                contested;
  logic                exe_grant;
  logic                lsu_grant;

  // EXE may not overwrite a register whose load is still in flight (WAW),
  // otherwise the late load return would clobber the newer EXE result.
  always_comb begin
    exe_eligible = exe_valid_i & ~pending[exe_rd_i] & ~rst;
    lsu_eligible = lsu_valid_i & ~rst;
    contested    = exe_eligible & lsu_eligible;
    // LSU normally wins contention; EXE is forced through after STARVE_MAX losses.
    exe_grant    = exe_eligible & (~lsu_eligible | (starve_cnt == CNT_MAX));
    lsu_grant    = lsu_eligible & ~exe_grant;
  end

  assign exe_ready_o = exe_grant;
  assign lsu_ready_o = lsu_grant;

  // Clear before set so a same-cycle issue to the returning register keeps it pending.
  always_comb begin
    pending_nxt = pending;
    if (lsu_grant) begin
      pending_nxt[lsu_rd_i] = 1'b0;
    end
    if (lsu_issue_i) begin
      pending_nxt[lsu_issue_rd_i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // A new load may only target a register whose previous load is retiring now.
    if (!rst && lsu_issue_i && (lsu_issue_rd_i != '0)
        && !(lsu_grant && (lsu_rd_i == lsu_issue_rd_i))) begin
      assert (!pending[lsu_issue_rd_i]);
    end

    if (rst) begin
      rf_we_o      <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_rd_data_o <= '0;
      pending      <= '0;
      starve_cnt   <= '0;
    end else begin
      pending <= pending_nxt;

      if (exe_grant) begin
        rf_we_o      <= (exe_rd_i != '0);
        rf_rd_addr_o <= exe_rd_i;
        rf_rd_data_o <= exe_data_i;
      end else if (lsu_grant) begin
        rf_we_o      <= (lsu_rd_i != '0);
        rf_rd_addr_o <= lsu_rd_i;
        rf_rd_data_o <= lsu_data_i;
      end else begin
        rf_we_o <= 1'b0;
      end

      // Only contested LSU wins count toward starvation; any EXE grant resets it.
      if (exe_grant) begin
        starve_cnt <= '0;
      end else if (lsu_grant && contested && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  assign pending_o     = pending;
  assign rs1_pending_o = pending[rs1_addr_i];
  assign rs2_pending_o = pending[rs2_addr_i];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                exe_valid_i;
  logic                exe_ready_o;
  logic [ADDR_W-1:0]   exe_rd_i;
  logic [DATA_W-1:0]   exe_data_i;
  logic                lsu_valid_i;
  logic                lsu_ready_o;
  logic [ADDR_W-1:0]   lsu_rd_i;
  logic [DATA_W-1:0]   lsu_data_i;
  logic                lsu_issue_i;
  logic [ADDR_W-1:0]   lsu_issue_rd_i;
  logic [ADDR_W-1:0]   rs1_addr_i;
  logic [ADDR_W-1:0]   rs2_addr_i;
  logic                rs1_pending_o;
  logic                rs2_pending_o;
  logic [NUM_REGS-1:0] pending_o;
  logic                rf_we_o;
  logic [ADDR_W-1:0]   rf_rd_addr_o;
  logic [DATA_W-1:0]   rf_rd_data_o;

  rf_wb_scheduler #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .exe_valid_i(exe_valid_i), .exe_ready_o(exe_ready_o),
    .exe_rd_i(exe_rd_i), .exe_data_i(exe_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_issue_i(lsu_issue_i), .lsu_issue_rd_i(lsu_issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_pending_o(rs1_pending_o), .rs2_pending_o(rs2_pending_o),
    .pending_o(pending_o),
    .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state: which registers await a load, how many contested
  // cycles in a row the LSU has won, and the write the port should show now.
  bit                m_pend [NUM_REGS];
  int                m_streak;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                m_valid = 1'b0;
  bit                g_exe;
  bit                g_lsu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [NUM_REGS-1:0] pend_bits();
    logic [NUM_REGS-1:0] p;
    for (int i = 0; i < NUM_REGS; i++) p[i] = m_pend[i];
    return p;
  endfunction

  // Entered at posedge+1 with inputs driven; checks at the falling edge,
  // advances the model across the next rising edge, returns at posedge+1.
  task automatic step();
    bit exe_el, lsu_el, both, exe_win, lsu_win;
    #4;
    exe_el  = exe_valid_i && !((exe_rd_i != 0) && m_pend[exe_rd_i]);
    lsu_el  = lsu_valid_i;
    both    = exe_el && lsu_el;
    exe_win = exe_el && (!lsu_el || (m_streak >= STARVE_MAX));
    lsu_win = lsu_el && !exe_win;
    if (rst) begin
      exe_win = 1'b0;
      lsu_win = 1'b0;
    end
    check("exe_ready", exe_ready_o, exe_win);
    check("lsu_ready", lsu_ready_o, lsu_win);
    if (m_valid) begin
      check("rf_we", rf_we_o, m_we);
      check("rf_addr", rf_rd_addr_o, m_addr);
      check("rf_data", rf_rd_data_o, m_data);
      check("pending", pending_o, pend_bits());
      check("rs1_pending", rs1_pending_o, m_pend[rs1_addr_i]);
      check("rs2_pending", rs2_pending_o, m_pend[rs2_addr_i]);
    end
    g_exe = exe_win;
    g_lsu = lsu_win;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
      m_streak = 0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_valid = 1'b1;
    end else begin
      m_we = 1'b0;
      if (exe_win) begin
        m_we = (exe_rd_i != 0); m_addr = exe_rd_i; m_data = exe_data_i;
      end else if (lsu_win) begin
        m_we = (lsu_rd_i != 0); m_addr = lsu_rd_i; m_data = lsu_data_i;
      end
      if (exe_win) m_streak = 0;
      else if (both && lsu_win && m_streak < STARVE_MAX) m_streak = m_streak + 1;
      if (lsu_win && lsu_rd_i != 0) m_pend[lsu_rd_i] = 1'b0;
      if (lsu_issue_i && lsu_issue_rd_i != 0) m_pend[lsu_issue_rd_i] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exe_valid_i = 1'b0; exe_rd_i = '0; exe_data_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
    lsu_issue_i = 1'b0; lsu_issue_rd_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0;
  endtask

  initial begin
    int cand[$];
    bit was_rst;
    bit exp_exe;

    // Reset with both requesters asserting
    idle_inputs();
    rst = 1'b1;
    exe_valid_i = 1'b1; exe_rd_i = 5'd3; exe_data_i = 32'h1111_1111;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_data_i = 32'h2222_2222;
    @(posedge clk);
    #1;
    step();
    step();
    check("t1_rf_we", rf_we_o, 1'b0);
    check("t1_pending", pending_o, 32'h0);
    check("t1_exe_ready", exe_ready_o, 1'b0);
    rst = 1'b0;
    idle_inputs();

    // Single EXE write, one cycle latency
    exe_valid_i = 1'b1; exe_rd_i = 5'd5; exe_data_i = 32'hDEAD_BEEF;
    step();
    check("t2_accept", g_exe, 1'b1);
    idle_inputs();
    check("t2_we", rf_we_o, 1'b1);
    check("t2_addr", rf_rd_addr_o, 5'd5);
    check("t2_data", rf_rd_data_o, 32'hDEAD_BEEF);
    step();
    check("t2_we_drop", rf_we_o, 1'b0);

    // Continuous contention: L,L,L,L,E repeating
    exe_valid_i = 1'b1; exe_rd_i = 5'd1; exe_data_i = 32'hE0E0_0001;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 32'h1515_0002;
    for (int i = 0; i < 10; i++) begin
      exp_exe = ((i % 5) == 4);
      step();
      check("t3_grant_exe", g_exe, exp_exe);
      check("t3_grant_lsu", g_lsu, !exp_exe);
    end
    idle_inputs();

    // Scoreboard RAW/WAW handling
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd7; rs1_addr_i = 5'd7;
    step();
    lsu_issue_i = 1'b0;
    #1;
    check("t4_rs1_pending", rs1_pending_o, 1'b1);
    exe_valid_i = 1'b1; exe_rd_i = 5'd7; exe_data_i = 32'h0000_0077;
    step();
    check("t4_exe_blocked", g_exe, 1'b0);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h0000_1234;
    step();
    check("t4_lsu_accept", g_lsu, 1'b1);
    check("t4_exe_still_blocked", g_exe, 1'b0);
    lsu_valid_i = 1'b0;
    check("t4_we", rf_we_o, 1'b1);
    check("t4_addr", rf_rd_addr_o, 5'd7);
    check("t4_data", rf_rd_data_o, 32'h0000_1234);
    check("t4_pend7_clear", pending_o[7], 1'b0);
    step();
    check("t4_exe_accept", g_exe, 1'b1);
    idle_inputs();
    check("t4_exe_data", rf_rd_data_o, 32'h0000_0077);

    // Set and clear of the same register in one cycle
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd9;
    step();
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h0000_0909;
    step();
    check("t5_lsu_accept", g_lsu, 1'b1);
    check("t5_pend9_kept", pending_o[9], 1'b1);
    lsu_issue_i = 1'b0;
    step();
    idle_inputs();
    check("t5_pend9_clear", pending_o[9], 1'b0);

    // x0 write suppressed, then reset mid-operation
    exe_valid_i = 1'b1; exe_rd_i = 5'd0; exe_data_i = 32'h0000_00AA;
    step();
    check("t6_x0_accept", g_exe, 1'b1);
    idle_inputs();
    check("t6_x0_we", rf_we_o, 1'b0);
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd3;
    step();
    lsu_issue_i = 1'b0;
    check("t6_pend3", pending_o[3], 1'b1);
    rst = 1'b1;
    exe_valid_i = 1'b1; exe_rd_i = 5'd4; exe_data_i = 32'h0000_4444;
    step();
    check("t6_rst_ready", g_exe, 1'b0);
    check("t6_rst_pending", pending_o, 32'h0);
    check("t6_rst_we", rf_we_o, 1'b0);
    rst = 1'b0;
    idle_inputs();

    // Randomised traffic against the model
    g_exe = 1'b0;
    g_lsu = 1'b0;
    was_rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (was_rst || g_exe || !exe_valid_i) begin
        exe_valid_i = ($urandom_range(0, 9) < 6);
        exe_rd_i    = ADDR_W'($urandom_range(0, 7));
        exe_data_i  = $urandom;
      end
      if (was_rst || g_lsu || !lsu_valid_i) begin
        cand.delete();
        for (int r = 1; r < 8; r++) if (m_pend[r]) cand.push_back(r);
        lsu_valid_i = ($urandom_range(0, 9) < 5);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
          lsu_rd_i = ADDR_W'(cand[$urandom_range(0, cand.size() - 1)]);
        else
          lsu_rd_i = ADDR_W'($urandom_range(0, 7));
        lsu_data_i = $urandom;
      end
      lsu_issue_rd_i = ADDR_W'($urandom_range(0, 7));
      lsu_issue_i    = ($urandom_range(0, 9) < 3) && !m_pend[lsu_issue_rd_i];
      rs1_addr_i     = ADDR_W'($urandom_range(0, 7));
      rs2_addr_i     = ADDR_W'($urandom_range(0, 7));
      rst            = ($urandom_range(0, 99) == 0);
      was_rst        = rst;
      step();
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
